// File: rtl/decompress_dma_if.sv
// rtl/decompress_dma_if.sv - decompressor and RAM-port signal bundle
interface decompress_dma_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int BUF_W  = 256
);
  logic [7:0]        in1;
  logic [7:0]        in2;
  logic              work;
  logic [BUF_W-1:0]  out;
  logic [31:0]       byteIndx;
  logic [2:0]        bitIndx;
  logic              done;
  logic [ADDR_W-1:0] ramAddress;
  logic [DATA_W-1:0] ramData;
  logic              read_signal;
  logic              write_signal;
  logic [DATA_W-1:0] ramDataOut;
  logic              doneRead;
  logic              doneWrite;

  modport slave (
    input  in1, in2, work, ramAddress, ramData, read_signal, write_signal,
    output out, byteIndx, bitIndx, done, ramDataOut, doneRead, doneWrite
  );

  modport master (
    output in1, in2, work, ramAddress, ramData, read_signal, write_signal,
    input  out, byteIndx, bitIndx, done, ramDataOut, doneRead, doneWrite
  );
endinterface

// File: rtl/decompress_dma.sv
// rtl/decompress_dma.sv - two-run RLE decompressor plus byte-wide RAM port
module decompress_dma #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int BUF_W  = 256
) (
  input  logic              clk,
  input  logic              RST,
  decompress_dma_if.slave   bus
);

  logic [BUF_W-1:0]  out_q, out_d;
  logic [31:0]       byte_indx_q, byte_indx_d;
  logic [2:0]        bit_indx_q, bit_indx_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] ram_data_out_q, ram_data_out_d;
  logic              done_read_q, done_read_d;
  logic              done_write_q, done_write_d;

  // Storage deliberately has no reset so contents survive RST.
  logic [DATA_W-1:0] mem_q [0:(2**ADDR_W)-1];

  logic [6:0] len1;
  logic [6:0] len2;
  logic [7:0] rep;

  assign len1 = bus.in1[6:0];
  assign len2 = bus.in2[6:0];
  assign rep  = {1'b0, len1} + {1'b0, len2};

  // Expand both runs MSB-first; bits past the second run are zero.
  always_comb begin
    out_d       = out_q;
    byte_indx_d = byte_indx_q;
    bit_indx_d  = bit_indx_q;
    done_d      = 1'b0;
    if (bus.work) begin
      done_d = 1'b1;
      for (int i = 0; i < BUF_W; i++) begin
        if (i < int'(len1)) begin
          out_d[BUF_W-1-i] = bus.in1[7];
        end else if (i < int'(rep)) begin
          out_d[BUF_W-1-i] = bus.in2[7];
        end else begin
          out_d[BUF_W-1-i] = 1'b0;
        end
      end
      byte_indx_d = {27'd0, rep[7:3]};
      bit_indx_d  = 3'd7 - rep[2:0];
    end
  end

  // RAM port response: a write takes priority and suppresses a same-cycle read.
  always_comb begin
    ram_data_out_d = ram_data_out_q;
    done_read_d    = 1'b0;
    done_write_d   = 1'b0;
    if (bus.write_signal) begin
      done_write_d = 1'b1;
    end else if (bus.read_signal) begin
      ram_data_out_d = mem_q[bus.ramAddress];
      done_read_d    = 1'b1;
    end
  end

  // Memory array write.
  always_ff @(posedge clk) begin
    if (bus.write_signal) begin
      mem_q[bus.ramAddress] <= bus.ramData;
    end
  end

  // Output state registers with asynchronous clear.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      out_q          <= '0;
      byte_indx_q    <= '0;
      bit_indx_q     <= 3'd7;
      done_q         <= 1'b0;
      ram_data_out_q <= '0;
      done_read_q    <= 1'b0;
      done_write_q   <= 1'b0;
    end else begin
      out_q          <= out_d;
      byte_indx_q    <= byte_indx_d;
      bit_indx_q     <= bit_indx_d;
      done_q         <= done_d;
      ram_data_out_q <= ram_data_out_d;
      done_read_q    <= done_read_d;
      done_write_q   <= done_write_d;
    end
  end

  assign bus.out        = out_q;
  assign bus.byteIndx   = byte_indx_q;
  assign bus.bitIndx    = bit_indx_q;
  assign bus.done       = done_q;
  assign bus.ramDataOut = ram_data_out_q;
  assign bus.doneRead   = done_read_q;
  assign bus.doneWrite  = done_write_q;

endmodule

// File: tb/tb_decompress_dma.sv
// tb/tb_decompress_dma.sv - randomized model-checked bench for decompress_dma
module tb_decompress_dma;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  bit   chk_en;

  decompress_dma_if bus ();

  decompress_dma dut (
    .clk (clk),
    .RST (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected state held by the reference model.
  logic [255:0] e_out;
  logic [31:0]  e_byte;
  logic [2:0]   e_bit;
  logic         e_done;
  logic [7:0]   e_rdo;
  logic         e_dr;
  logic         e_dw;
  logic [7:0]   mdl [int];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Build the buffer as a bit stream: run A, then run B, then zero padding.
  function automatic logic [255:0] expand(input logic [7:0] a, input logic [7:0] b);
    bit q[$];
    logic [255:0] r;
    repeat (int'(a[6:0])) q.push_back(a[7]);
    repeat (int'(b[6:0])) q.push_back(b[7]);
    r = '0;
    foreach (q[k]) r[255-k] = q[k];
    return r;
  endfunction

  // Reference model: what the outputs must be after each edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_out = '0; e_byte = 0; e_bit = 3'd7; e_done = 0;
      e_rdo = 0; e_dr = 0; e_dw = 0;
    end else begin
      if (bus.work) begin
        int total;
        total  = int'(bus.in1[6:0]) + int'(bus.in2[6:0]);
        e_out  = expand(bus.in1, bus.in2);
        e_byte = total / 8;
        e_bit  = 3'(7 - (total % 8));
        e_done = 1;
      end else begin
        e_done = 0;
      end
      e_dr = 0; e_dw = 0;
      if (bus.write_signal) begin
        mdl[int'(bus.ramAddress)] = bus.ramData;
        e_dw = 1;
      end else if (bus.read_signal) begin
        if (mdl.exists(int'(bus.ramAddress))) e_rdo = mdl[int'(bus.ramAddress)];
        e_dr = 1;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("out", bus.out, e_out);
      chk("byteIndx", 256'(bus.byteIndx), 256'(e_byte));
      chk("bitIndx", 256'(bus.bitIndx), 256'(e_bit));
      chk("done", 256'(bus.done), 256'(e_done));
      chk("ramDataOut", 256'(bus.ramDataOut), 256'(e_rdo));
      chk("doneRead", 256'(bus.doneRead), 256'(e_dr));
      chk("doneWrite", 256'(bus.doneWrite), 256'(e_dw));
    end
  end

  task automatic idle_inputs();
    bus.in1 = 0; bus.in2 = 0; bus.work = 0;
    bus.ramAddress = 0; bus.ramData = 0;
    bus.read_signal = 0; bus.write_signal = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [255:0] lit;

  initial begin
    n_cmp = 0; n_bad = 0; chk_en = 0;
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out", bus.out, 256'd0);
    chk("rst_bit", 256'(bus.bitIndx), 256'd7);
    chk("rst_done", 256'(bus.done), 256'd0);
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    #2;

    // Three runs of 1 then five of 0: next free bit is MSB of byte 1.
    bus.in1 = 8'h83; bus.in2 = 8'h05; bus.work = 1;
    step();
    chk("t1_done", 256'(bus.done), 256'd1);
    chk("t1_out", bus.out, {8'hE0, 248'd0});
    chk("t1_byte", 256'(bus.byteIndx), 256'd1);
    chk("t1_bit", 256'(bus.bitIndx), 256'd7);

    bus.in1 = 8'hFF; bus.in2 = 8'hFF;
    step();
    lit = {{254{1'b1}}, 2'b00};
    chk("t2_out", bus.out, lit);
    chk("t2_byte", 256'(bus.byteIndx), 256'd31);
    chk("t2_bit", 256'(bus.bitIndx), 256'd1);

    bus.in1 = 8'h00; bus.in2 = 8'h85;
    step();
    lit = {5'b11111, 251'd0};
    chk("t3_out", bus.out, lit);
    chk("t3_byte", 256'(bus.byteIndx), 256'd0);
    chk("t3_bit", 256'(bus.bitIndx), 256'd2);
    bus.work = 0;
    step();
    chk("t3_done_low", 256'(bus.done), 256'd0);
    chk("t3_out_hold", bus.out, lit);

    bus.ramAddress = 16'h1234; bus.ramData = 8'hA5; bus.write_signal = 1;
    step();
    chk("t4_dw", 256'(bus.doneWrite), 256'd1);
    bus.write_signal = 0;
    step();
    chk("t4_dw_pulse", 256'(bus.doneWrite), 256'd0);
    bus.read_signal = 1;
    step();
    chk("t4_rd", 256'(bus.ramDataOut), 256'hA5);
    chk("t4_dr", 256'(bus.doneRead), 256'd1);
    bus.read_signal = 0;
    step();
    chk("t4_dr_pulse", 256'(bus.doneRead), 256'd0);

    bus.ramAddress = 16'h0010; bus.ramData = 8'h3C;
    bus.read_signal = 1; bus.write_signal = 1;
    step();
    chk("t5_dw", 256'(bus.doneWrite), 256'd1);
    chk("t5_dr", 256'(bus.doneRead), 256'd0);
    chk("t5_rdo_hold", 256'(bus.ramDataOut), 256'hA5);
    bus.write_signal = 0;
    step();
    chk("t5_rd", 256'(bus.ramDataOut), 256'h3C);
    bus.read_signal = 0;

    // Random traffic on both halves at once.
    for (int n = 0; n < 500; n++) begin
      int op;
      logic [15:0] a;
      bus.in1  = 8'($urandom);
      bus.in2  = 8'($urandom);
      bus.work = ($urandom_range(0, 3) != 0);
      a  = 16'h0100 + 16'($urandom_range(0, 7));
      op = $urandom_range(0, 3);
      if ((op == 2) && !mdl.exists(int'(a))) op = 1;
      bus.ramAddress   = a;
      bus.ramData      = 8'($urandom);
      bus.write_signal = (op == 1) || (op == 3);
      bus.read_signal  = (op == 2) || (op == 3);
      step();
    end

    // Asynchronous reset in the middle of active work.
    bus.in1 = 8'h8A; bus.in2 = 8'h07; bus.work = 1;
    bus.ramAddress = 16'h1234; bus.read_signal = 1; bus.write_signal = 0;
    step();
    chk("t6_pre_done", 256'(bus.done), 256'd1);
    chk("t6_pre_rdo", 256'(bus.ramDataOut), 256'hA5);
    chk_en = 0;
    #1;
    rst_n = 0;
    #1;
    chk("t6_done", 256'(bus.done), 256'd0);
    chk("t6_dr", 256'(bus.doneRead), 256'd0);
    chk("t6_dw", 256'(bus.doneWrite), 256'd0);
    chk("t6_rdo", 256'(bus.ramDataOut), 256'd0);
    chk("t6_out", bus.out, 256'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    #2;
    bus.ramAddress = 16'h1234; bus.read_signal = 1;
    step();
    chk("t6_keep", 256'(bus.ramDataOut), 256'hA5);
    bus.read_signal = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
